// File: rtl/frame_fifo_sc.sv
// Single-clock frame FIFO: frames are written speculatively and become visible to the reader
// only once committed by in_good; bad or overflowing frames are rolled back and reported.
module frame_fifo_sc #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_good,
    input  logic              in_bad,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              drop_pulse
);

    localparam int unsigned WordW = DATA_W + 1;
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {WIdle, WFrame, WWait, WDrop} wr_state_e;
    typedef enum logic {RIdle, RFrame} rd_state_e;

    logic [WordW-1:0]  r_mem [Depth];

    logic [DATA_W-1:0] r_in_data;
    logic              r_in_valid;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_wr_start;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic              r_drop_pulse;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    wr_state_e         r_wr_state;
    rd_state_e         r_rd_state;

    wr_state_e         w_wr_state_d;
    rd_state_e         w_rd_state_d;
    logic [ADDR_W-1:0] w_wr_ptr_d;
    logic [ADDR_W-1:0] w_wr_start_d;
    logic [ADDR_W-1:0] w_wr_inc;
    logic [CNT_W-1:0]  w_frame_cnt_d;
    logic              w_rise;
    logic              w_end;
    logic              w_pulse;
    logic              w_ovf;
    logic              w_commit;
    logic              w_we;
    logic              w_drop;
    logic              w_cnt_full;
    logic              w_slot_free;
    logic              w_last_hs;
    logic              w_rd_en;

    assign w_rise      = in_valid & ~r_in_valid;
    // The word held in r_in_data is the frame's last one when in_valid has just dropped.
    assign w_end       = r_in_valid & ~in_valid;
    assign w_pulse     = in_good | in_bad;
    assign w_wr_inc    = r_wr_ptr + ADDR_W'(1);
    assign w_ovf       = (w_wr_inc == r_rd_ptr);
    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_last_hs   = r_out_valid & out_ready & r_out_last;

    // Commit may coincide with the end-word write when the pulse arrives as in_valid falls.
    assign w_commit = in_good & ~in_bad &
                      ((r_wr_state == WWait) | ((r_wr_state == WFrame) & w_end & ~w_ovf));

    always_comb begin
        w_frame_cnt_d = r_frame_cnt;
        if (w_commit && !w_last_hs) begin
            w_frame_cnt_d = r_frame_cnt + CNT_W'(1);
        end else if (!w_commit && w_last_hs) begin
            w_frame_cnt_d = r_frame_cnt - CNT_W'(1);
        end
    end

    assign w_cnt_full = (w_frame_cnt_d == CntMax);

    // Write FSM
    always_comb begin
        w_wr_state_d = r_wr_state;
        w_wr_ptr_d   = r_wr_ptr;
        w_wr_start_d = r_wr_start;
        w_we         = 1'b0;
        w_drop       = 1'b0;
        unique case (r_wr_state)
            WIdle: begin
                if (w_rise) begin
                    if (w_cnt_full) begin
                        w_wr_state_d = WDrop;
                        w_drop       = 1'b1;
                    end else begin
                        w_wr_state_d = WFrame;
                    end
                end
            end
            WFrame: begin
                if (r_in_valid) begin
                    if (w_ovf) begin
                        w_wr_ptr_d   = r_wr_start;
                        w_drop       = 1'b1;
                        w_wr_state_d = (w_end && w_pulse) ? WIdle : WDrop;
                    end else begin
                        w_we       = 1'b1;
                        w_wr_ptr_d = w_wr_inc;
                        if (w_end) begin
                            if (in_bad) begin
                                w_wr_ptr_d   = r_wr_start;
                                w_drop       = 1'b1;
                                w_wr_state_d = WIdle;
                            end else if (in_good) begin
                                w_wr_start_d = w_wr_inc;
                                w_wr_state_d = WIdle;
                            end else begin
                                w_wr_state_d = WWait;
                            end
                        end
                    end
                end
            end
            WWait: begin
                if (w_pulse) begin
                    if (in_bad) begin
                        w_wr_ptr_d = r_wr_start;
                        w_drop     = 1'b1;
                    end else begin
                        w_wr_start_d = r_wr_ptr;
                    end
                    w_wr_state_d = WIdle;
                    if (w_rise) begin
                        w_wr_state_d = w_cnt_full ? WDrop : WFrame;
                        w_drop       = w_drop | w_cnt_full;
                    end
                end
            end
            WDrop: begin
                if (!in_valid && w_pulse) begin
                    w_wr_state_d = WIdle;
                end
            end
            default: w_wr_state_d = WIdle;
        endcase
    end

    // Read FSM; a new frame is chained on the last-word handshake to avoid a bubble.
    always_comb begin
        w_rd_state_d = r_rd_state;
        w_rd_en      = 1'b0;
        unique case (r_rd_state)
            RIdle: begin
                if ((r_frame_cnt != '0) && w_slot_free) begin
                    w_rd_en      = 1'b1;
                    w_rd_state_d = RFrame;
                end
            end
            RFrame: begin
                if (r_out_last) begin
                    if (w_last_hs) begin
                        if (r_frame_cnt > CNT_W'(1)) begin
                            w_rd_en = 1'b1;
                        end else begin
                            w_rd_state_d = RIdle;
                        end
                    end
                end else begin
                    w_rd_en = w_slot_free;
                end
            end
            default: w_rd_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= {w_end, r_in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_data    <= '0;
            r_in_valid   <= 1'b0;
            r_wr_ptr     <= '0;
            r_wr_start   <= '0;
            r_wr_state   <= WIdle;
            r_frame_cnt  <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_in_data    <= in_data;
            r_in_valid   <= in_valid;
            r_wr_ptr     <= w_wr_ptr_d;
            r_wr_start   <= w_wr_start_d;
            r_wr_state   <= w_wr_state_d;
            r_frame_cnt  <= w_frame_cnt_d;
            r_drop_pulse <= w_drop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr    <= '0;
            r_rd_state  <= RIdle;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_d;
            if (w_rd_en) begin
                r_rd_ptr                 <= r_rd_ptr + ADDR_W'(1);
                {r_out_last, r_out_data} <= r_mem[r_rd_ptr];
                r_out_valid              <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign frame_cnt  = r_frame_cnt;
    assign drop_pulse = r_drop_pulse;

endmodule

// File: doc/frame_fifo_sc.md
FRAME_FIFO_SC -- requirements
Module: frame_fifo_sc

Interface
REQ-001 Parameter DATA_W, default 8, payload width per word.
REQ-002 Parameter ADDR_W, default 11, buffer depth 2^ADDR_W words.
REQ-003 Parameter CNT_W, default 7, width of stored-frame counter.
REQ-004 clk  input  1  single clock for all logic and the inferred buffer.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_data  input  DATA_W  frame payload, sampled when in_valid=1.
REQ-007 in_valid  input  1  high for a contiguous run of cycles per frame; 0-to-1 edge starts a frame, 1-to-0 edge ends it.
REQ-008 in_good  input  1  one-cycle pulse after frame end: commit the frame.
REQ-009 in_bad  input  1  one-cycle pulse after frame end: discard the frame.
REQ-010 out_data  output  DATA_W  frame payload.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_last  output  1  final word of frame, qualified by out_valid.
REQ-013 out_ready  input  1  sink accepts word when out_valid and out_ready are both 1.
REQ-014 frame_cnt  output  CNT_W  committed frames not yet fully read.
REQ-015 drop_pulse  output  1  one-cycle pulse per discarded frame (bad or overflow).

Function
REQ-016 Buffer word SHALL be DATA_W+1 bits: {end_flag, data}.
REQ-017 Write SHALL lag input by one cycle; end_flag=1 on the word whose next-cycle in_valid is 0.
REQ-018 Write FSM states: W_IDLE, W_FRAME, W_WAIT, W_DROP.
REQ-019 W_IDLE->W_FRAME on in_valid rising edge; W_FRAME->W_WAIT after the end_flag word is written; W_WAIT->W_IDLE on in_good or in_bad.
REQ-020 wr_ptr SHALL advance per written word; wr_start SHALL hold the first address of the uncommitted frame.
REQ-021 On in_good in W_WAIT: wr_start<=wr_ptr, frame_cnt increments.
REQ-022 On in_bad in W_WAIT: wr_ptr<=wr_start, drop_pulse=1; in_good and in_bad in the same cycle SHALL be treated as bad.
REQ-023 Overflow: if a write would make (wr_ptr+1) mod 2^ADDR_W equal rd_ptr, the word SHALL not be written, wr_ptr<=wr_start, FSM->W_DROP, drop_pulse=1.
REQ-024 Frame start while frame_cnt = 2^CNT_W-1 SHALL enter W_DROP directly, drop_pulse=1.
REQ-025 W_DROP SHALL ignore data until in_valid falls, then ignore the next in_good/in_bad and return to W_IDLE.
REQ-026 Read FSM states: R_IDLE, R_FRAME; R_IDLE->R_FRAME when frame_cnt != 0; R_FRAME->R_IDLE on handshake of out_last word.
REQ-027 Buffer read SHALL be synchronous, one-cycle latency; out_data/out_valid/out_last SHALL be registered.
REQ-028 While out_valid=1 and out_ready=0, out_data/out_last SHALL hold stable and no read SHALL issue.
REQ-029 Read SHALL not issue beyond a fetched end_flag word; back-to-back frames SHALL stream with no idle cycle when frame_cnt>1.
REQ-030 frame_cnt SHALL decrement on out_last handshake; simultaneous commit and last handshake SHALL leave it unchanged.
REQ-031 Pointers SHALL wrap modulo 2^ADDR_W; one-word minimum frame SHALL be supported.
REQ-032 Full sustained throughput: one word per cycle in and out.

Reset
REQ-033 rst_n=0 SHALL immediately clear wr_ptr, wr_start, rd_ptr, frame_cnt, out_valid, out_last, drop_pulse, out_data to 0 and set both FSMs to idle.
REQ-034 Reset mid-frame SHALL lose all stored and partial frames; first frame after rst_n rises SHALL be stored normally.

Verification
REQ-035 Bench: 64-byte frame 0x00..0x3F + in_good, out_ready=1 -> 64 words out in order, out_last on 0x3F, frame_cnt 0->1->0.
REQ-036 Bench: frame A good, frame B bad, frame C good -> output A then C only, one drop_pulse, wr_ptr equals start + len(A)+len(C).
REQ-037 Bench: out_ready=0, 2100-byte frame with ADDR_W=11 -> drop_pulse=1, frame_cnt stays 0, subsequent 10-byte good frame read intact.
REQ-038 Bench: out_ready toggled randomly 50% over 20 random frames -> byte-exact match, no duplicated or skipped word, out_data stable while stalled.
REQ-039 Bench: 1-byte frames back-to-back with in_good and concurrent reading -> every word has out_last=1, frame_cnt never exceeds 2.
REQ-040 Bench: rst_n asserted mid-frame with 3 frames stored -> outputs 0 asynchronously, after release next good frame output alone.
